data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 31 +++
 rtl/data_mem_ctrl_dmem_array.sv | 38 +++
 rtl/data_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM state encodings,
// default geometry and timing, and the latency counter width.
package data_mem_ctrl_pkg;

  // Default byte-address width; the word depth is 2^(width-2).
  localparam int MEM_RAM_WIDTH_DEF = 10;

  // Default request-to-finished latency in cycles (legal range 1..15).
  localparam int LATENCY_DEF = 2;

  // Counter wide enough for the largest legal latency.
  localparam int CNT_W = 4;

  // Controller states:
  //   ST_IDLE : waiting for a read or write request
  //   ST_BUSY : latency count-down, access performed at terminal count
  //   ST_ACK  : completion pulse is visible
  //   ST_HOLD : waiting for the CPU to drop its request
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Value loaded into the down-counter when a request is accepted.
  function automatic logic [CNT_W-1:0] cnt_load(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port word storage for the data memory controller.
// Synchronous write, registered read. Contents are not reset; only the read
// register is cleared by clrn. rzero forces the read register to zero, which
// the controller uses for rejected (misaligned) reads.
module dmem_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          we,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  // Store the word on a write strobe; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Capture read data on a read strobe and hold it until the next read.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? 32'h0 : mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: level-request / pulse-completion handshake with a
// fixed access latency in front of a single-port word array.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN enables the misalignment check
// (sticky mem_err, suppressed write, zero read data, normal handshake timing).
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int MEM_RAM_WIDTH = MEM_RAM_WIDTH_DEF,
  parameter int LATENCY       = LATENCY_DEF
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     mem_re,
  input  logic                     mem_we,
  input  logic [MEM_RAM_WIDTH-1:0] mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic [31:0]              mem_data,
  output logic                     mem_r_finished,
  output logic                     mem_w_finished,
  output logic                     mem_err
);

  localparam int IDX_W = MEM_RAM_WIDTH - 2;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_write;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  logic req;
  logic access;
  logic arr_we;
  logic arr_re;
  logic arr_rzero;

  assign req    = mem_re | mem_we;
  // The access happens on the edge that leaves BUSY at terminal count, the
  // same edge that raises the finished pulse.
  assign access = (state == ST_BUSY) && (cnt == '0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic mis_q;
  logic err_q;

  // Record misalignment of the accepted request and keep the sticky error.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else if ((state == ST_IDLE) && req) begin
      mis_q <= (mem_addr[1:0] != 2'b00);
      if (mem_addr[1:0] != 2'b00) begin
        err_q <= 1'b1;
      end
    end
  end

  assign arr_we    = access & op_write & ~mis_q;
  assign arr_rzero = mis_q;
  assign mem_err   = err_q;
`else
  // Byte-lane bits play no part in indexing when the check is disabled.
  logic unused_low_bits;
  assign unused_low_bits = ^mem_addr[1:0];

  assign arr_we    = access & op_write;
  assign arr_rzero = 1'b0;
  assign mem_err   = 1'b0;
`endif

  assign arr_re = access & ~op_write;

  // Handshake FSM with latency counter, request latches and completion pulses.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      op_write       <= 1'b0;
      idx_q          <= '0;
      wdata_q        <= '0;
      mem_r_finished <= 1'b0;
      mem_w_finished <= 1'b0;
    end else begin
      mem_r_finished <= 1'b0;
      mem_w_finished <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Write wins when both requests are raised together.
            op_write <= mem_we;
            idx_q    <= mem_addr[MEM_RAM_WIDTH-1:2];
            wdata_q  <= mem_wdata;
            cnt      <= cnt_load(LATENCY);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            mem_w_finished <= op_write;
            mem_r_finished <= ~op_write;
            state          <= ST_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          // A request still held after completion must not be served again.
          if (!mem_re && !mem_we) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .AW(IDX_W)
  ) u_array (
    .clk  (clk),
    .clrn (clrn),
    .we   (arr_we),
    .re   (arr_re),
    .rzero(arr_rzero),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(mem_data)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a timeline model of the handshake
// plus a word-array model predicts every output on every cycle; directed
// cases pin the model with literal values, then randomized traffic follows.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  localparam int W     = 10;
  localparam int L     = 2;
  localparam int DEPTH = 1 << (W - 2);
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clrn = 1'b1;
  logic          mem_re = 1'b0;
  logic          mem_we = 1'b0;
  logic [W-1:0]  mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_data;
  logic          mem_r_finished;
  logic          mem_w_finished;
  logic          mem_err;

  data_mem_ctrl #(
    .MEM_RAM_WIDTH(W),
    .LATENCY      (L)
  ) dut (
    .clk           (clk),
    .clrn          (clrn),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data      (mem_data),
    .mem_r_finished(mem_r_finished),
    .mem_w_finished(mem_w_finished),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_rp  = 0;
  int n_wp  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeline view: a request seen while free completes exactly L edges later;
  // afterwards the port is blocked until the request is seen low at least two
  // edges after completion.
  logic [31:0] mdl [DEPTH];
  bit          m_busy = 1'b0;
  bit          m_hold = 1'b0;
  bit          m_opw = 1'b0;
  bit          m_mis = 1'b0;
  int          m_idx = 0;
  int          m_done = 0;
  int          m_rel = 0;
  int          ecnt = 0;
  logic [31:0] m_wd = '0;
  logic        exp_rf = 1'b0;
  logic        exp_wf = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_data = '0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_busy   = 1'b0;
      m_hold   = 1'b0;
      exp_rf   = 1'b0;
      exp_wf   = 1'b0;
      exp_err  = 1'b0;
      exp_data = '0;
    end else begin
      ecnt++;
      exp_rf = 1'b0;
      exp_wf = 1'b0;
      if (!m_busy && !m_hold) begin
        if (mem_we || mem_re) begin
          m_busy = 1'b1;
          m_opw  = mem_we;
          m_idx  = int'(mem_addr) / 4;
          m_wd   = mem_wdata;
          m_done = ecnt + L;
          m_mis  = ALIGN && (int'(mem_addr) % 4 != 0);
          if (m_mis) exp_err = 1'b1;
        end
      end else if (m_busy) begin
        if (ecnt == m_done) begin
          m_busy = 1'b0;
          m_hold = 1'b1;
          m_rel  = ecnt + 2;
          if (m_opw) begin
            exp_wf = 1'b1;
            if (!m_mis) mdl[m_idx] = m_wd;
          end else begin
            exp_rf   = 1'b1;
            exp_data = m_mis ? 32'h0 : mdl[m_idx];
          end
        end
      end else if (ecnt >= m_rel && !mem_re && !mem_we) begin
        m_hold = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_r_finished", 32'(mem_r_finished), 32'(exp_rf));
      chk("mem_w_finished", 32'(mem_w_finished), 32'(exp_wf));
      chk("mem_data", mem_data, exp_data);
      chk("mem_err", 32'(mem_err), 32'(exp_err));
      if (mem_r_finished === 1'b1) n_rp++;
      if (mem_w_finished === 1'b1) n_wp++;
    end
  end

  // One CPU transaction: raise request, wait for its pulse (bounded), keep the
  // request 'hold' extra cycles, then drop it. Address/data are scrambled
  // after the request has been sampled.
  task automatic do_op(input bit we, input bit re, input logic [W-1:0] a,
                       input logic [31:0] d, input int hold,
                       output int lat, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    lat = -1;
    rd  = '0;
    @(posedge clk);
    #1;
    mem_we = we; mem_re = re; mem_addr = a; mem_wdata = d;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if ((we ? mem_w_finished : mem_r_finished) === 1'b1) begin
        got = 1'b1;
        lat = n - 2;
        rd  = mem_data;
      end else if (n >= 2) begin
        mem_addr  = W'($urandom);
        mem_wdata = $urandom;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s handshake: no finished pulse within 40 cycles", we ? "write" : "read");
    end
    repeat (hold + 1) @(posedge clk);
    #1;
    mem_we = 1'b0;
    mem_re = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int          lat;
    int          r0;
    int          w0;
    logic [31:0] rd;
    logic [11:0] wide;

    #1 clrn = 1'b0;
    #2 chk_en = 1'b1;
    @(negedge clk);
    chk("reset mem_data", mem_data, 32'h0);
    chk("reset mem_r_finished", 32'(mem_r_finished), 32'h0);
    chk("reset mem_w_finished", 32'(mem_w_finished), 32'h0);
    chk("reset mem_err", 32'(mem_err), 32'h0);
    #2 clrn = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b1, 1'b0, W'(i * 4), $urandom, 0, lat, rd);
    end

    // Write then read with exact latency.
    do_op(1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 0, lat, rd);
    chk("write latency", 32'(lat), 32'd2);
    do_op(1'b0, 1'b1, 10'h010, 32'h0, 0, lat, rd);
    chk("read latency", 32'(lat), 32'd2);
    chk("read 0x010", rd, 32'hDEADBEEF);

    // Read held past completion gives a single pulse.
    r0 = n_rp;
    do_op(1'b0, 1'b1, 10'h010, 32'h0, 3, lat, rd);
    repeat (4) @(negedge clk);
    chk("held read pulse count", 32'(n_rp - r0), 32'd1);

    // Simultaneous read and write: write only, load data untouched.
    r0 = n_rp;
    w0 = n_wp;
    do_op(1'b1, 1'b1, 10'h020, 32'h12345678, 0, lat, rd);
    @(negedge clk);
    chk("simultaneous read pulses", 32'(n_rp - r0), 32'd0);
    chk("simultaneous write pulses", 32'(n_wp - w0), 32'd1);
    chk("simultaneous mem_data kept", mem_data, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, 10'h020, 32'h0, 0, lat, rd);
    chk("read 0x020", rd, 32'h12345678);

    // Reset during BUSY drops the write.
    do_op(1'b1, 1'b0, 10'h030, 32'h0BADF00D, 0, lat, rd);
    w0 = n_wp;
    @(posedge clk);
    #1;
    mem_we = 1'b1; mem_addr = 10'h030; mem_wdata = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    #2 clrn = 1'b0;
    @(negedge clk);
    chk("mid-busy reset mem_data", mem_data, 32'h0);
    chk("mid-busy reset mem_w_finished", 32'(mem_w_finished), 32'h0);
    mem_we = 1'b0;
    #2 clrn = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid-busy reset write pulses", 32'(n_wp - w0), 32'd0);
    do_op(1'b0, 1'b1, 10'h030, 32'h0, 0, lat, rd);
    chk("0x030 kept after reset", rd, 32'h0BADF00D);

    // Address wrap at the top of the array.
    do_op(1'b1, 1'b0, 10'h3FC, 32'h00000055, 0, lat, rd);
    wide = 12'h7FC;
    do_op(1'b0, 1'b1, wide[W-1:0], 32'h0, 0, lat, rd);
    chk("read 0x7FC wraps", rd, 32'h00000055);
    do_op(1'b0, 1'b1, 10'h3FC, 32'h0, 0, lat, rd);
    chk("read 0x3FC", rd, 32'h00000055);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    do_op(1'b1, 1'b0, 10'h010, 32'hCAFE0001, 0, lat, rd);
    w0 = n_wp;
    do_op(1'b1, 1'b0, 10'h011, 32'hFFFF0000, 0, lat, rd);
    chk("misaligned mem_err", 32'(mem_err), 32'h1);
    chk("misaligned write pulse", 32'(n_wp - w0), 32'd1);
    do_op(1'b0, 1'b1, 10'h010, 32'h0, 0, lat, rd);
    chk("misaligned write suppressed", rd, 32'hCAFE0001);
`else
    do_op(1'b1, 1'b0, 10'h011, 32'hCAFE0002, 0, lat, rd);
    do_op(1'b0, 1'b1, 10'h010, 32'h0, 0, lat, rd);
    chk("low address bits ignored", rd, 32'hCAFE0002);
    chk("mem_err tied low", 32'(mem_err), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 2);
      do_op(k != 1, k != 0, W'($urandom), $urandom, $urandom_range(0, 2), lat, rd);
      chk("random latency", 32'(lat), 32'(L));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
